// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: frames parallel bytes as start, LSB-first data, optional parity
// and stop bits, and keeps the baud generator in reset between frames so every frame is phase-aligned.
module uart_tx_serializer #(
    parameter int DATA_BITS     = 8,
    parameter int TICKS_PER_BIT = 16,
    parameter int PARITY_EN     = 0,
    parameter int PARITY_ODD    = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic                 CLK288MHZ,
    input  logic                 resetN,
    input  logic                 tick,
    input  logic [DATA_BITS-1:0] txData,
    input  logic                 txValid,
    output logic                 txReady,
    output logic                 baudReset,
    output logic                 txOut,
    output logic                 txBusy,
    output logic                 frameDone
);

    localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                 state_r, state_s;
    logic [TW-1:0]          tick_cnt_r, tick_cnt_s;
    logic [3:0]             bit_cnt_r, bit_cnt_s;
    logic [DATA_BITS-1:0]   shift_r, shift_s;
    logic                   parity_r, parity_s;
    logic                   tx_out_s, tx_ready_s, tx_busy_s, baud_reset_s, frame_done_s;
    logic                   accept_s, bit_end_s;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    assign accept_s  = txValid && txReady;
    assign bit_end_s = (state_r != IDLE) && tick && (tick_cnt_r == TICK_LAST);

    // State and registered-output update
    always_ff @(posedge CLK288MHZ) begin
        if (!resetN) begin
            state_r    <= IDLE;
            tick_cnt_r <= '0;
            bit_cnt_r  <= 4'd0;
            shift_r    <= '0;
            parity_r   <= 1'b0;
            txOut      <= 1'b1;
            txReady    <= 1'b1;
            txBusy     <= 1'b0;
            baudReset  <= 1'b1;
            frameDone  <= 1'b0;
        end else begin
            state_r    <= state_s;
            tick_cnt_r <= tick_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            parity_r   <= parity_s;
            txOut      <= tx_out_s;
            txReady    <= tx_ready_s;
            txBusy     <= tx_busy_s;
            baudReset  <= baud_reset_s;
            frameDone  <= frame_done_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:   if (accept_s) state_s = START; else state_s = IDLE;
            START:  if (bit_end_s) state_s = DATA; else state_s = START;
            DATA: begin
                if (bit_end_s && (bit_cnt_r == DATA_LAST)) begin
                    state_s = (PARITY_EN != 0) ? PARITY : STOP;
                end else begin
                    state_s = DATA;
                end
            end
            PARITY: if (bit_end_s) state_s = STOP; else state_s = PARITY;
            STOP: begin
                if (bit_end_s && (bit_cnt_r == STOP_LAST)) state_s = IDLE;
                else state_s = STOP;
            end
            default: state_s = IDLE;
        endcase
    end

    // Next values of the datapath and registered outputs
    always_comb begin
        tick_cnt_s   = tick_cnt_r;
        bit_cnt_s    = bit_cnt_r;
        shift_s      = shift_r;
        parity_s     = parity_r;
        tx_out_s     = txOut;
        tx_ready_s   = txReady;
        tx_busy_s    = txBusy;
        baud_reset_s = baudReset;
        frame_done_s = 1'b0;

        // Ticks only count while a frame is active; the terminal tick rolls the bit over.
        if ((state_r != IDLE) && tick) begin
            tick_cnt_s = bit_end_s ? '0 : (tick_cnt_r + TW'(1));
        end else begin
            tick_cnt_s = tick_cnt_r;
        end

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    shift_s      = txData;
                    parity_s     = parity_of(txData);
                    tx_out_s     = 1'b0;
                    tx_ready_s   = 1'b0;
                    tx_busy_s    = 1'b1;
                    baud_reset_s = 1'b0;
                    tick_cnt_s   = '0;
                end else begin
                    tx_out_s = 1'b1;
                end
            end
            START: begin
                if (bit_end_s) begin
                    tx_out_s  = shift_r[0];
                    bit_cnt_s = 4'd0;
                end else begin
                    tx_out_s = 1'b0;
                end
            end
            DATA: begin
                if (!bit_end_s) begin
                    tx_out_s = txOut;
                end else if (bit_cnt_r == DATA_LAST) begin
                    tx_out_s  = (PARITY_EN != 0) ? parity_r : 1'b1;
                    bit_cnt_s = 4'd0;
                end else begin
                    shift_s   = shift_r >> 1;
                    tx_out_s  = shift_r[1];
                    bit_cnt_s = bit_cnt_r + 4'd1;
                end
            end
            PARITY: begin
                if (bit_end_s) tx_out_s = 1'b1;
                else tx_out_s = txOut;
            end
            STOP: begin
                if (!bit_end_s) begin
                    tx_out_s = 1'b1;
                end else if (bit_cnt_r == STOP_LAST) begin
                    tx_ready_s   = 1'b1;
                    tx_busy_s    = 1'b0;
                    baud_reset_s = 1'b1;
                    frame_done_s = 1'b1;
                    bit_cnt_s    = 4'd0;
                end else begin
                    bit_cnt_s = bit_cnt_r + 4'd1;
                end
            end
            default: begin
                tx_out_s     = 1'b1;
                tx_ready_s   = 1'b1;
                tx_busy_s    = 1'b0;
                baud_reset_s = 1'b1;
                tick_cnt_s   = '0;
                bit_cnt_s    = 4'd0;
            end
        endcase
    end

endmodule
